// File: rtl/ibex_rf_wport_ctrl_if.sv
// Signal bundle for the register-file write-port controller.
// The slave modport is the controller's own view. The master modport is the
// view of the surrounding pipeline and register file that drive and observe it.
interface ibex_rf_wport_ctrl_if #(
   parameter int DataWidth = 32
);
   logic                 a_we_i;
   logic [4:0]           a_waddr_i;
   logic [DataWidth-1:0] a_wdata_i;
   logic                 b_valid_i;
   logic                 b_ready_o;
   logic [4:0]           b_waddr_i;
   logic [DataWidth-1:0] b_wdata_i;
   logic                 b_squash_o;
   logic                 clear_req_i;
   logic                 clear_busy_o;
   logic                 clear_err_o;
   logic                 rf_we_o;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;

   modport slave (
      input  a_we_i, a_waddr_i, a_wdata_i,
      input  b_valid_i, b_waddr_i, b_wdata_i,
      input  clear_req_i,
      output b_ready_o, b_squash_o,
      output clear_busy_o, clear_err_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o
   );

   modport master (
      output a_we_i, a_waddr_i, a_wdata_i,
      output b_valid_i, b_waddr_i, b_wdata_i,
      output clear_req_i,
      input  b_ready_o, b_squash_o,
      input  clear_busy_o, clear_err_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o
   );
endinterface

// File: rtl/ibex_rf_wport_ctrl.sv
// Write-port controller for the flip-flop register file.
// Shares the single regfile write port between the ID/EX writeback (A, never
// stalled) and the LSU late-load writeback (B, valid/ready with a one-entry
// holding buffer). A younger A write to the same address discards the B entry.
// Optional feature macro IBEX_RF_CLEAR_EN: when defined, a clear sequencer
// zeroes registers 1..NUM_WORDS-1 through the same port; when undefined no FSM
// or counter is built and the clear outputs are tied low.
module ibex_rf_wport_ctrl #(
   parameter bit RV32E     = 1'b0,
   parameter int DataWidth = 32
) (
   input logic                  clk_i,
   input logic                  rst_i,
   ibex_rf_wport_ctrl_if.slave  bus
);

   localparam int         NumWords = 2 ** (RV32E ? 4 : 5);
   localparam logic [4:0] LastAddr = 5'(NumWords - 1);

   logic                 r_bufValid;
   logic [4:0]           r_bufAddr;
   logic [DataWidth-1:0] r_bufData;

   logic                 w_idle;
   logic                 w_inClear;
   logic                 w_clearWrite;
   logic [4:0]           w_clearCnt;
   logic                 w_bReady;
   logic                 w_xfer;
   logic                 w_captureHit;
   logic                 w_bufHit;
   logic                 w_capture;
   logic                 w_drain;
   logic                 w_rfWe;
   logic [4:0]           w_rfWaddr;
   logic [DataWidth-1:0] w_rfWdata;

   assign w_bReady     = !rst_i && !r_bufValid && w_idle;
   assign w_xfer       = bus.b_valid_i && w_bReady;
   assign w_captureHit = bus.a_we_i && w_xfer && (bus.a_waddr_i == bus.b_waddr_i);
   assign w_bufHit     = bus.a_we_i && r_bufValid && (bus.a_waddr_i == r_bufAddr);
   assign w_capture    = bus.a_we_i && w_xfer && !w_captureHit;
   assign w_drain      = !bus.a_we_i && r_bufValid;

`ifdef IBEX_RF_CLEAR_EN
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clrState_e;

   clrState_e  r_state;
   clrState_e  w_stateNext;
   logic [4:0] r_cnt;
   logic       r_pending;
   logic       r_clearErr;
   logic       w_clearStart;

   // A clear may only begin once the holding buffer is empty, so a request
   // seen with a full buffer is remembered until the buffer drains.
   assign w_clearStart = (bus.clear_req_i || r_pending) && !r_bufValid;
   assign w_clearWrite = w_inClear && !bus.a_we_i && !r_bufValid;
   assign w_clearCnt   = r_cnt;

   // Clear FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Clear FSM next state: leave CLEAR right after the last register is zeroed.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_clearStart) w_stateNext = CLEAR;
         CLEAR:   if (w_clearWrite && (r_cnt == LastAddr)) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Clear FSM outputs.
   always_comb begin
      w_inClear = (r_state == CLEAR);
      w_idle    = (r_state == IDLE);
   end

   // Address counter advances only on cycles where the sequencer owns the
   // port; it is rewound to 1 on exit so the next clear starts from x1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= 5'd1;
      end else if (w_clearWrite) begin
         r_cnt <= (r_cnt == LastAddr) ? 5'd1 : r_cnt + 5'd1;
      end
   end

   // Pending request tracking and the sticky "A wrote during a clear" flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pending  <= 1'b0;
         r_clearErr <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_pending <= (bus.clear_req_i || r_pending) && r_bufValid;
         end else begin
            r_pending <= 1'b0;
         end
         if ((r_state == CLEAR) && bus.a_we_i) begin
            r_clearErr <= 1'b1;
         end
      end
   end

   assign bus.clear_busy_o = !rst_i && w_inClear;
   assign bus.clear_err_o  = !rst_i && r_clearErr;
`else
   logic w_unusedClearReq;

   assign w_unusedClearReq = bus.clear_req_i;
   assign w_idle           = 1'b1;
   assign w_inClear        = 1'b0;
   assign w_clearWrite     = 1'b0;
   assign w_clearCnt       = '0;
   assign bus.clear_busy_o = 1'b0;
   assign bus.clear_err_o  = 1'b0;
`endif

   // Holding buffer: a hit by a younger A write discards the entry, an A-idle
   // cycle drains it, and a B transfer that collides with A is parked here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bufValid <= 1'b0;
         r_bufAddr  <= '0;
         r_bufData  <= '0;
      end else if (w_bufHit || w_drain) begin
         r_bufValid <= 1'b0;
      end else if (w_capture) begin
         r_bufValid <= 1'b1;
         r_bufAddr  <= bus.b_waddr_i;
         r_bufData  <= bus.b_wdata_i;
      end
   end

   // Port arbitration: A first, then buffered B, then direct B, then clear.
   always_comb begin
      w_rfWe    = 1'b0;
      w_rfWaddr = '0;
      w_rfWdata = '0;
      if (!rst_i) begin
         if (bus.a_we_i) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = bus.a_waddr_i;
            w_rfWdata = bus.a_wdata_i;
         end else if (r_bufValid) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = r_bufAddr;
            w_rfWdata = r_bufData;
         end else if (w_xfer) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = bus.b_waddr_i;
            w_rfWdata = bus.b_wdata_i;
         end else if (w_clearWrite) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = w_clearCnt;
         end
      end
   end

   assign bus.b_ready_o  = w_bReady;
   assign bus.b_squash_o = !rst_i && (w_bufHit || w_captureHit);
   assign bus.rf_we_o    = w_rfWe;
   assign bus.rf_waddr_o = w_rfWaddr;
   assign bus.rf_wdata_o = w_rfWdata;

endmodule

// File: tb/tb_ibex_rf_wport_ctrl.sv
// Self-checking bench for ibex_rf_wport_ctrl: a vector table for the basic
// handshake cases, hand-written clear sequences, and a randomized run against
// a behavioural model of the write-port rules.
module tb_ibex_rf_wport_ctrl;

   localparam int DataWidth = 32;
   localparam int NumWords  = 32;
`ifdef IBEX_RF_CLEAR_EN
   localparam bit ClearEn = 1'b1;
`else
   localparam bit ClearEn = 1'b0;
`endif

   typedef struct {
      logic        aWe;
      logic [4:0]  aAddr;
      logic [31:0] aData;
      logic        bValid;
      logic [4:0]  bAddr;
      logic [31:0] bData;
      logic        rstIn;
      logic        expWe;
      logic [4:0]  expAddr;
      logic [31:0] expData;
      logic        expReady;
      logic        expSquash;
   } vec_t;

   logic        clk;
   logic        rst;
   int          checks;
   int          errors;
   logic [31:0] rfShadow [32];
   vec_t        vecs [13];

   bit          mBufValid;
   logic [4:0]  mBufAddr;
   logic [31:0] mBufData;
   bit          mClearing;
   int          mNext;
   bit          mPending;
   bit          mErr;

   logic        eWe;
   logic [4:0]  eAddr;
   logic [31:0] eData;
   logic        eReady;
   logic        eSquash;
   logic        eBusy;
   logic        eErr;

   ibex_rf_wport_ctrl_if #(.DataWidth(DataWidth)) bus ();
   ibex_rf_wport_ctrl_if #(.DataWidth(DataWidth)) bus16 ();

   ibex_rf_wport_ctrl #(.RV32E(1'b0), .DataWidth(DataWidth)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   ibex_rf_wport_ctrl #(.RV32E(1'b1), .DataWidth(DataWidth)) dut16 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic aWe, input logic [4:0] aAddr, input logic [31:0] aData,
                                input logic bValid, input logic [4:0] bAddr, input logic [31:0] bData,
                                input logic clr, input logic rstIn);
      bus.a_we_i      = aWe;
      bus.a_waddr_i   = aAddr;
      bus.a_wdata_i   = aData;
      bus.b_valid_i   = bValid;
      bus.b_waddr_i   = bAddr;
      bus.b_wdata_i   = bData;
      bus.clear_req_i = clr;
      rst             = rstIn;
   endtask

   task automatic checkOutput(input string tag);
      check($sformatf("%s.we", tag), 32'(bus.rf_we_o), 32'(eWe));
      if (eWe || rst) begin
         check($sformatf("%s.addr", tag), 32'(bus.rf_waddr_o), 32'(eAddr));
         check($sformatf("%s.data", tag), bus.rf_wdata_o, eData);
      end
      check($sformatf("%s.ready", tag), 32'(bus.b_ready_o), 32'(eReady));
      check($sformatf("%s.squash", tag), 32'(bus.b_squash_o), 32'(eSquash));
      check($sformatf("%s.busy", tag), 32'(bus.clear_busy_o), 32'(eBusy));
      check($sformatf("%s.err", tag), 32'(bus.clear_err_o), 32'(eErr));
   endtask

   task automatic waitSample;
      @(negedge clk);
   endtask

   task automatic advance;
      if (bus.rf_we_o) rfShadow[bus.rf_waddr_o] = bus.rf_wdata_o;
      @(posedge clk);
      #1;
   endtask

   // Expected port outputs for the current inputs under the priority rules.
   task automatic modelEval;
      bit xfer;
      eReady  = !rst && !mBufValid && !mClearing;
      xfer    = bus.b_valid_i && eReady;
      eWe     = 1'b0;
      eAddr   = '0;
      eData   = '0;
      eSquash = 1'b0;
      if (!rst) begin
         if (bus.a_we_i) begin
            eWe     = 1'b1;
            eAddr   = bus.a_waddr_i;
            eData   = bus.a_wdata_i;
            eSquash = (mBufValid && mBufAddr == bus.a_waddr_i) || (xfer && bus.b_waddr_i == bus.a_waddr_i);
         end else if (mBufValid) begin
            eWe   = 1'b1;
            eAddr = mBufAddr;
            eData = mBufData;
         end else if (xfer) begin
            eWe   = 1'b1;
            eAddr = bus.b_waddr_i;
            eData = bus.b_wdata_i;
         end else if (mClearing) begin
            eWe   = 1'b1;
            eAddr = 5'(mNext);
         end
      end
      eBusy = !rst && mClearing;
      eErr  = !rst && mErr;
   endtask

   // Model state update for the coming clock edge.
   task automatic modelCommit;
      bit xfer;
      xfer = bus.b_valid_i && !rst && !mBufValid && !mClearing;
      if (rst) begin
         mBufValid = 0; mClearing = 0; mNext = 1; mPending = 0; mErr = 0;
      end else begin
         if (mClearing && bus.a_we_i) mErr = 1;
         if (mClearing) begin
            if (!bus.a_we_i && !mBufValid) begin
               if (mNext == NumWords - 1) begin
                  mClearing = 0;
                  mNext     = 1;
               end else begin
                  mNext++;
               end
            end
         end else if (ClearEn && (bus.clear_req_i || mPending)) begin
            if (mBufValid) mPending = 1;
            else begin
               mClearing = 1;
               mPending  = 0;
            end
         end
         if (bus.a_we_i) begin
            if (mBufValid && mBufAddr == bus.a_waddr_i) mBufValid = 0;
            else if (xfer && bus.b_waddr_i != bus.a_waddr_i) begin
               mBufValid = 1;
               mBufAddr  = bus.b_waddr_i;
               mBufData  = bus.b_wdata_i;
            end
         end else if (mBufValid) begin
            mBufValid = 0;
         end
      end
   endtask

   initial begin
      int busy32;
      int busy16;
      int next32;
      int next16;
      int expCnt;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) rfShadow[i] = 32'hA5A5_0000 | 32'(i);
      bus16.a_we_i = 0; bus16.a_waddr_i = 0; bus16.a_wdata_i = 0;
      bus16.b_valid_i = 0; bus16.b_waddr_i = 0; bus16.b_wdata_i = 0;
      bus16.clear_req_i = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      advance;

      vecs[0]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd7,  32'h22,       1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd7,  32'h22,       1'b0, 1'b1, 5'd3,  32'h11,       1'b1, 1'b0};
      vecs[3]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd8,  32'h88,       1'b0, 1'b1, 5'd4,  32'h44,       1'b0, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd7,  32'h22,       1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[6]  = '{1'b1, 5'd1,  32'h55,       1'b1, 5'd9,  32'h99,       1'b0, 1'b1, 5'd1,  32'h55,       1'b1, 1'b0};
      vecs[7]  = '{1'b1, 5'd9,  32'h33,       1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd9,  32'h33,       1'b0, 1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd12, 32'hAA,       1'b1, 5'd12, 32'hBB,       1'b0, 1'b1, 5'd12, 32'hAA,       1'b1, 1'b1};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77,       1'b0, 1'b1, 5'd0,  32'h77,       1'b1, 1'b0};
      vecs[12] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].aWe, vecs[i].aAddr, vecs[i].aData, vecs[i].bValid,
                       vecs[i].bAddr, vecs[i].bData, 1'b0, vecs[i].rstIn);
         eWe = vecs[i].expWe; eAddr = vecs[i].expAddr; eData = vecs[i].expData;
         eReady = vecs[i].expReady; eSquash = vecs[i].expSquash; eBusy = 1'b0; eErr = 1'b0;
         waitSample;
         checkOutput($sformatf("vec%0d", i));
         advance;
      end
      check("squash.rf9", rfShadow[9], 32'h33);
      check("squash.rf12", rfShadow[12], 32'hAA);

      // Clear pulse on both register-file sizes at once.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      bus16.clear_req_i = 1;
      waitSample;
      check("clr.startBusy", 32'(bus.clear_busy_o), 32'd0);
      advance;
      bus.clear_req_i = 0;
      bus16.clear_req_i = 0;
      busy32 = 0; busy16 = 0; next32 = 1; next16 = 1;
      for (int c = 0; c < 40; c++) begin
         waitSample;
         if (bus.clear_busy_o) begin
            busy32++;
            check("clr32.we", 32'(bus.rf_we_o), 32'd1);
            check("clr32.addr", 32'(bus.rf_waddr_o), 32'(next32));
            check("clr32.data", bus.rf_wdata_o, 32'd0);
            check("clr32.ready", 32'(bus.b_ready_o), 32'd0);
            next32++;
         end
         if (bus16.clear_busy_o) begin
            busy16++;
            check("clr16.addr", 32'(bus16.rf_waddr_o), 32'(next16));
            next16++;
         end
         advance;
      end
      check("clr32.len", 32'(busy32), ClearEn ? 32'd31 : 32'd0);
      check("clr16.len", 32'(busy16), ClearEn ? 32'd15 : 32'd0);

`ifdef IBEX_RF_CLEAR_EN
      for (int i = 1; i < 32; i++) check($sformatf("clr.rf%0d", i), rfShadow[i], 32'd0);

      // A write lands in the cycle the sequencer would zero x10.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      advance;
      bus.clear_req_i = 0;
      expCnt = 1;
      for (int c = 1; c <= 40; c++) begin
         bus.a_we_i    = (c == 10);
         bus.a_waddr_i = 5'd20;
         bus.a_wdata_i = 32'h1234;
         waitSample;
         if (expCnt <= 31) begin
            check($sformatf("intf%0d.busy", c), 32'(bus.clear_busy_o), 32'd1);
            check($sformatf("intf%0d.err", c), 32'(bus.clear_err_o), (c > 10) ? 32'd1 : 32'd0);
            if (c == 10) begin
               check("intf.aAddr", 32'(bus.rf_waddr_o), 32'd20);
               check("intf.aData", bus.rf_wdata_o, 32'h1234);
            end else begin
               check($sformatf("intf%0d.addr", c), 32'(bus.rf_waddr_o), 32'(expCnt));
               check($sformatf("intf%0d.data", c), bus.rf_wdata_o, 32'd0);
               expCnt++;
            end
         end else begin
            check($sformatf("intf%0d.idle", c), 32'(bus.clear_busy_o), 32'd0);
            check($sformatf("intf%0d.sticky", c), 32'(bus.clear_err_o), 32'd1);
         end
         advance;
      end
      check("intf.rf20", rfShadow[20], 32'd0);

      // Reset arrives while the sequencer holds cnt=12.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      advance;
      bus.clear_req_i = 0;
      for (int c = 1; c <= 11; c++) advance;
      rst = 1;
      waitSample;
      check("rstmid.we", 32'(bus.rf_we_o), 32'd0);
      check("rstmid.busy", 32'(bus.clear_busy_o), 32'd0);
      check("rstmid.err", 32'(bus.clear_err_o), 32'd0);
      check("rstmid.ready", 32'(bus.b_ready_o), 32'd0);
      advance;
      rst = 0;
      waitSample;
      check("rstpost.we", 32'(bus.rf_we_o), 32'd0);
      check("rstpost.busy", 32'(bus.clear_busy_o), 32'd0);
      check("rstpost.err", 32'(bus.clear_err_o), 32'd0);
      check("rstpost.ready", 32'(bus.b_ready_o), 32'd1);
      advance;
      bus.clear_req_i = 1;
      advance;
      bus.clear_req_i = 0;
      waitSample;
      check("restart.busy", 32'(bus.clear_busy_o), 32'd1);
      check("restart.addr", 32'(bus.rf_waddr_o), 32'd1);
      for (int c = 0; c < 40; c++) advance;
`endif

      // Randomized traffic against the model.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      modelCommit;
      advance;
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 63) == 0), ($urandom_range(0, 199) == 0));
         if ($urandom_range(0, 3) == 0) bus.a_waddr_i = 5'($urandom_range(0, 31));
         modelEval;
         waitSample;
         checkOutput($sformatf("rnd%0d", n));
         modelCommit;
         advance;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
